mw_buffer: RTL and testbench

Memory/Writeback pipeline register of the processor datapath. Captures the register-write control, both destination register addresses, both write-back data words and the R15 data word produced by the memory stage, and presents them to the writeback stage one clock later. Pure state element, no arithmetic.

---
 rtl/mw_pkg.sv | 11 +
 rtl/mw_buffer_pipe_reg.sv | 27 ++
 rtl/mw_buffer.sv | 50 +++++
 tb/tb_mw_buffer.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/mw_pkg.sv
// Shared constants and write-enable encodings for the memory/writeback stage boundary.
package mw_pkg;
  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 4;
  localparam int RWRITE_W = 2;

  localparam logic [RWRITE_W-1:0] RW_NONE = 2'b00;
  localparam logic [RWRITE_W-1:0] RW_OP1  = 2'b01;
  localparam logic [RWRITE_W-1:0] RW_OP2  = 2'b10;
  localparam logic [RWRITE_W-1:0] RW_BOTH = 2'b11;
endpackage

// File: rtl/mw_buffer_pipe_reg.sv
// One pipeline field: async active-low clear, synchronous clear (bubble) and hold.
module pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         hold,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q_d, q_q;

  // clr outranks hold so a flushed stage never keeps stale write enables
  always_comb begin
    q_d = q_q;
    if (clr)        q_d = '0;
    else if (!hold) q_d = d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q_q <= '0;
    else        q_q <= q_d;
  end

  assign q = q_q;
endmodule

// File: rtl/mw_buffer.sv
// Memory/Writeback pipeline register; each field is an independent pipe_reg.
// Define MWBUFFER_HOLD_EN to add stall/flush ports.
module mw_buffer
  import mw_pkg::*;
#(
  parameter int DATA_W = mw_pkg::DATA_W,
  parameter int ADDR_W = mw_pkg::ADDR_W
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [RWRITE_W-1:0] rWrite,
  input  logic [ADDR_W-1:0]   op1,
  input  logic [ADDR_W-1:0]   op2,
  input  logic [DATA_W-1:0]   op1data,
  input  logic [DATA_W-1:0]   op2data,
  input  logic [DATA_W-1:0]   r15data,
`ifdef MWBUFFER_HOLD_EN
  input  logic                stall,
  input  logic                flush,
`endif
  output logic [RWRITE_W-1:0] rWriteOut,
  output logic [ADDR_W-1:0]   op1Out,
  output logic [ADDR_W-1:0]   op2Out,
  output logic [DATA_W-1:0]   op1dataOut,
  output logic [DATA_W-1:0]   op2dataOut,
  output logic [DATA_W-1:0]   r15dataOut
);
  logic hold, clr;

`ifdef MWBUFFER_HOLD_EN
  assign hold = stall;
  assign clr  = flush;
`else
  assign hold = 1'b0;
  assign clr  = 1'b0;
`endif

  pipe_reg #(.W(RWRITE_W)) u_rwrite (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clr(clr), .d(rWrite), .q(rWriteOut));
  pipe_reg #(.W(ADDR_W)) u_op1 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clr(clr), .d(op1), .q(op1Out));
  pipe_reg #(.W(ADDR_W)) u_op2 (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clr(clr), .d(op2), .q(op2Out));
  pipe_reg #(.W(DATA_W)) u_op1data (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clr(clr), .d(op1data), .q(op1dataOut));
  pipe_reg #(.W(DATA_W)) u_op2data (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clr(clr), .d(op2data), .q(op2dataOut));
  pipe_reg #(.W(DATA_W)) u_r15data (
    .clk(clk), .rst_n(rst_n), .hold(hold), .clr(clr), .d(r15data), .q(r15dataOut));
endmodule

// File: tb/tb_mw_buffer.sv
// Randomized bench for mw_buffer: model = "outputs equal the input vector seen at the last edge".
module tb_mw_buffer;
  typedef struct packed {
    logic [1:0]  rw;
    logic [3:0]  op1;
    logic [3:0]  op2;
    logic [15:0] d1;
    logic [15:0] d2;
    logic [15:0] r15;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic stall = 1'b0;
  logic flush = 1'b0;
  vec_t in_v = '0;
  vec_t exp_v = '0;
  vec_t dut_v;
  int   checks = 0;
  int   errors = 0;

  logic [1:0]  rWriteOut;
  logic [3:0]  op1Out, op2Out;
  logic [15:0] op1dataOut, op2dataOut, r15dataOut;

  always #5 clk = ~clk;

  mw_buffer dut (
    .clk(clk), .rst_n(rst_n),
    .rWrite(in_v.rw), .op1(in_v.op1), .op2(in_v.op2),
    .op1data(in_v.d1), .op2data(in_v.d2), .r15data(in_v.r15),
`ifdef MWBUFFER_HOLD_EN
    .stall(stall), .flush(flush),
`endif
    .rWriteOut(rWriteOut), .op1Out(op1Out), .op2Out(op2Out),
    .op1dataOut(op1dataOut), .op2dataOut(op2dataOut), .r15dataOut(r15dataOut)
  );

  assign dut_v = '{rw: rWriteOut, op1: op1Out, op2: op2Out,
                   d1: op1dataOut, d2: op2dataOut, r15: r15dataOut};

  // Reference: snapshot of the inputs at the most recent edge out of reset
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) exp_v = '0;
`ifdef MWBUFFER_HOLD_EN
    else if (flush) exp_v = '0;
    else if (!stall) exp_v = in_v;
`else
    else exp_v = in_v;
`endif
  end

  task automatic chk(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got rw=%b op1=%h op2=%h d1=%h d2=%h r15=%h expected rw=%b op1=%h op2=%h d1=%h d2=%h r15=%h",
               name, act.rw, act.op1, act.op2, act.d1, act.d2, act.r15,
               exp.rw, exp.op1, exp.op2, exp.d1, exp.d2, exp.r15);
    end
  endtask

  always @(negedge clk) chk("cycle", dut_v, exp_v);

  function automatic vec_t rnd();
    vec_t v;
    v = '{rw: 2'($urandom), op1: 4'($urandom), op2: 4'($urandom),
          d1: 16'($urandom), d2: 16'($urandom), r15: 16'($urandom)};
    return v;
  endfunction

  vec_t cap_v, mid_v, keep_v;
  vec_t b2b [8];

  initial begin
    cap_v = '{rw: 2'b00, op1: 4'd0, op2: 4'd1, d1: 16'h00FF, d2: 16'h0082, r15: 16'h0015};
    mid_v = '{rw: 2'b01, op1: 4'd1, op2: 4'd4, d1: 16'h00CC, d2: 16'h0031, r15: 16'h0090};
    b2b[0] = '{2'b10, 4'hF, 4'h0, 16'hFFFF, 16'h0000, 16'hFFFF};
    b2b[1] = '{2'b11, 4'h0, 4'hF, 16'h0000, 16'hFFFF, 16'h0000};
    b2b[2] = '{2'b01, 4'h5, 4'hA, 16'h1234, 16'h5678, 16'h9ABC};
    b2b[3] = '{2'b00, 4'hA, 4'h5, 16'hDEAD, 16'hBEEF, 16'hCAFE};
    b2b[4] = '{2'b11, 4'h3, 4'hC, 16'hFFFF, 16'hFFFF, 16'hFFFF};
    b2b[5] = '{2'b10, 4'hC, 4'h3, 16'h0000, 16'h0000, 16'h0000};
    b2b[6] = '{2'b01, 4'h7, 4'h8, 16'hA5A5, 16'h5A5A, 16'h0F0F};
    b2b[7] = '{2'b11, 4'h8, 4'h7, 16'h0001, 16'h8000, 16'h7FFE};

    // Reset with arbitrary inputs
    in_v = rnd();
    #1 chk("reset_imm", dut_v, '0);
    repeat (2) @(posedge clk);
    #2 in_v = rnd();
    #1 chk("reset_held", dut_v, '0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    in_v = cap_v;
    @(posedge clk);
    #1 chk("capture", dut_v, cap_v);

    // Mid-cycle change invisible until the next edge
    #1 in_v = mid_v;
    #2 chk("mid_hold", dut_v, cap_v);
    @(posedge clk);
    #1 chk("mid_capture", dut_v, mid_v);

    // Back-to-back, each vector appears exactly one edge later
    for (int i = 0; i < 8; i++) begin
      #1 in_v = b2b[i];
      @(posedge clk);
      #1 chk("b2b", dut_v, b2b[i]);
    end

    // Random traffic
    for (int i = 0; i < 200; i++) begin
      #1 in_v = rnd();
      @(posedge clk);
    end

    // Async reset mid-operation
    #1 in_v = '{2'b11, 4'h9, 4'h6, 16'h1111, 16'h2222, 16'h3333};
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 chk("async_clear", dut_v, '0);
    @(posedge clk);
    #1 chk("async_held", dut_v, '0);
    #1 rst_n = 1'b1;
    keep_v = rnd();
    in_v = keep_v;
    @(posedge clk);
    #1 chk("post_reset_capture", dut_v, keep_v);

`ifdef MWBUFFER_HOLD_EN
    // Stall two cycles with changing inputs
    #1 stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_v = rnd();
      @(posedge clk);
      #1 chk("stall_frozen", dut_v, keep_v);
      #1;
    end
    flush = 1'b1;
    in_v = rnd();
    @(posedge clk);
    #1 chk("flush_over_stall", dut_v, '0);
    #1 stall = 1'b0;
    flush = 1'b0;
    for (int i = 0; i < 300; i++) begin
      in_v = rnd();
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 5) == 0);
      @(posedge clk);
      #2;
    end
    stall = 1'b0;
    flush = 1'b0;
`endif

    repeat (3) @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
